// File: rtl/wb_gpio_irq_if.sv
// Wishbone slave bundle for the GPIO port: strobe, write enable,
// address, write data, acknowledge and read data.
interface wb_gpio_irq_if #(
    parameter int WB_DATA_WIDTH = 8,
    parameter int WB_ADDR_WIDTH = 3
) ();
    logic                     stb_i;
    logic                     we_i;
    logic [WB_ADDR_WIDTH-1:0] adr_i;
    logic [WB_DATA_WIDTH-1:0] dat_i;
    logic                     ack_o;
    logic [WB_DATA_WIDTH-1:0] dat_o;

    modport master (
        output stb_i, we_i, adr_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  stb_i, we_i, adr_i, dat_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO port with per-pin direction, synchronised inputs,
// edge-detect sticky W1C status and a registered level interrupt.
module wb_gpio_irq #(
    parameter int WB_DATA_WIDTH = 8,
    parameter int WB_ADDR_WIDTH = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    wb_gpio_irq_if.slave             wb,
    output logic                     irq_o,
    inout  wire  [WB_DATA_WIDTH-1:0] gpio
);
    localparam int N = WB_DATA_WIDTH;

    logic [N-1:0] out_q;
    logic [N-1:0] dir_q;
    logic [N-1:0] ie_q;
    logic [N-1:0] rise_en_q;
    logic [N-1:0] fall_en_q;
    logic [N-1:0] status_q;
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] prev;
    logic [1:0]   settle;

    logic         access;
    logic         wr;
    logic [2:0]   sel;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic [N-1:0] rdata;

    assign access = wb.stb_i & ~wb.ack_o;
    assign wr     = access & wb.we_i;
    assign sel    = wb.adr_i[2:0];

    // Edges are masked until the synchroniser has flushed post-reset zeros.
    assign rise = (settle == 2'd0) ? (sync2 & ~prev) : '0;
    assign fall = (settle == 2'd0) ? (~sync2 & prev) : '0;
    assign set  = (rise & rise_en_q) | (fall & fall_en_q);
    assign clr  = (wr && sel == 3'd6) ? wb.dat_i : '0;

    for (genvar i = 0; i < N; i++) begin : g_pad
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_comb begin
        rdata = '0;
        unique case (sel)
            3'd0:    rdata = sync2;
            3'd1:    rdata = out_q;
            3'd2:    rdata = dir_q;
            3'd3:    rdata = ie_q;
            3'd4:    rdata = rise_en_q;
            3'd5:    rdata = fall_en_q;
            3'd6:    rdata = status_q;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q     <= '0;
            dir_q     <= '0;
            ie_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            settle    <= 2'd3;
            wb.ack_o  <= 1'b0;
            wb.dat_o  <= '0;
            irq_o     <= 1'b0;
        end else begin
            sync1    <= gpio;
            sync2    <= sync1;
            prev     <= sync2;
            if (settle != 2'd0)
                settle <= settle - 2'd1;
            wb.ack_o <= access;
            if (access && !wb.we_i)
                wb.dat_o <= rdata;
            if (wr) begin
                unique case (sel)
                    3'd1:    out_q     <= wb.dat_i;
                    3'd2:    dir_q     <= wb.dat_i;
                    3'd3:    ie_q      <= wb.dat_i;
                    3'd4:    rise_en_q <= wb.dat_i;
                    3'd5:    fall_en_q <= wb.dat_i;
                    default: ;
                endcase
            end
            // A new edge on the same cycle as its W1C clear keeps the flag.
            status_q <= (status_q & ~clr) | set;
            irq_o    <= |(status_q & ie_q);
        end
    end
endmodule

// File: tb/tb_wb_gpio_irq.sv
// Randomised and directed bench for wb_gpio_irq against a
// register-file / pin-history reference model.
module tb_wb_gpio_irq;
    localparam int N  = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_gpio_irq_if #(.WB_DATA_WIDTH(N), .WB_ADDR_WIDTH(AW)) bus ();

    wire  [N-1:0] gpio;
    logic         irq;
    logic [N-1:0] tb_pin;
    logic [N-1:0] tb_oe;

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign gpio[i] = tb_oe[i] ? tb_pin[i] : 1'bz;
    end

    wb_gpio_irq #(.WB_DATA_WIDTH(N), .WB_ADDR_WIDTH(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus),
        .irq_o (irq),
        .gpio  (gpio)
    );

    // Reference model: register file by address plus history of pin samples.
    logic [N-1:0] m_reg [0:7];
    logic [N-1:0] seen [$];
    logic         m_ack;
    logic         m_irq;
    logic [N-1:0] m_dat;
    int           m_age;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] pins;
        logic [N-1:0] rd;
        logic [N-1:0] nstat;
        logic [2:0]   a;
        bit           acc;
        pins = (m_reg[2] & m_reg[1]) | (~m_reg[2] & tb_pin);
        a    = bus.adr_i[2:0];
        if (rst) begin
            for (int k = 0; k < 8; k++) m_reg[k] = '0;
            m_ack = 0;
            m_irq = 0;
            m_dat = '0;
            m_age = 0;
            seen  = {};
            repeat (3) seen.push_back('0);
        end else begin
            acc   = bus.stb_i && !m_ack;
            rd    = (a == 3'd0) ? seen[1] : m_reg[a];
            nstat = m_reg[6];
            if (acc && bus.we_i && a == 3'd6) nstat &= ~bus.dat_i;
            // seen[1] is the synchronised level, seen[2] the one before it
            if (m_age >= 3)
                nstat |= (seen[1] & ~seen[2] & m_reg[4])
                       | (~seen[1] & seen[2] & m_reg[5]);
            m_irq = |(m_reg[6] & m_reg[3]);
            if (acc && bus.we_i && a >= 3'd1 && a <= 3'd5)
                m_reg[a] = bus.dat_i;
            m_reg[6] = nstat;
            if (acc && !bus.we_i) m_dat = rd;
            m_ack = acc;
            seen.push_front(pins);
            void'(seen.pop_back());
            m_age++;
        end
        @(posedge clk);
        #1 tb_oe = ~m_reg[2];
        #1;
        check("ack", 32'(bus.ack_o), 32'(m_ack));
        check("irq", 32'(irq), 32'(m_irq));
        check("dat", 32'(bus.dat_o), 32'(m_dat));
        check("pad", 32'(gpio & m_reg[2]), 32'(m_reg[1] & m_reg[2]));
    endtask

    task automatic bus_op(input bit we, input int adr, input logic [N-1:0] d,
                          output logic [N-1:0] q);
        bus.stb_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr[AW-1:0];
        bus.dat_i = d;
        step();
        q = bus.dat_o;
        bus.stb_i = 1'b0;
        step();
    endtask

    task automatic wr(input int adr, input logic [N-1:0] d);
        logic [N-1:0] q;
        bus_op(1'b1, adr, d, q);
    endtask

    task automatic rd(input int adr, output logic [N-1:0] q);
        bus_op(1'b0, adr, '0, q);
    endtask

    initial begin
        logic [N-1:0] q;
        rst       = 1'b1;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        tb_oe     = '1;
        tb_pin    = 8'hA5;

        // reset with pins high; rising-edge enable written on first cycle
        step();
        step();
        rst = 1'b0;
        wr(4, 8'hFF);
        repeat (4) step();
        rd(6, q); check("rst_status", 32'(q), 32'h00);
        rd(0, q); check("rst_in", 32'(q), 32'hA5);
        for (int k = 1; k <= 5; k++) begin
            if (k != 4) begin
                rd(k, q);
                check("rst_reg", 32'(q), 32'h00);
            end
        end
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_pads", 32'(gpio), 32'hA5);

        // strobe held high: ack every other cycle
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = 3'd1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("hs_ack", 32'(bus.ack_o), 32'(k % 2 == 0));
        end
        bus.stb_i = 1'b0;
        step();

        // output drive and readback
        wr(2, 8'h0F);
        wr(1, 8'h3C);
        repeat (3) step();
        check("out_pad", 32'(gpio[3:0]), 32'hC);
        rd(0, q); check("out_in", 32'(q[3:0]), 32'hC);

        // rising edge on pin0 -> flag, then irq one cycle later
        tb_pin = 8'h00;
        wr(2, 8'h00);
        wr(1, 8'h00);
        wr(4, 8'h01);
        wr(5, 8'h00);
        wr(3, 8'h01);
        repeat (4) step();
        wr(6, 8'hFF);
        step();
        tb_pin[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("edge_irq", 32'(irq), 32'(k >= 4));
        end
        rd(6, q); check("edge_stat", 32'(q), 32'h01);
        tb_pin[0] = 1'b0;
        repeat (5) step();
        rd(6, q); check("fall_off", 32'(q), 32'h01);

        // W1C against a simultaneous new rise
        wr(3, 8'h03);
        wr(4, 8'h03);
        tb_pin[1] = 1'b1;
        repeat (5) step();
        rd(6, q); check("w1c_pre", 32'(q), 32'h03);
        tb_pin[0] = 1'b1;
        step();
        step();
        wr(6, 8'h01);
        rd(6, q); check("w1c_race", 32'(q), 32'h03);
        wr(6, 8'h01);
        rd(6, q); check("w1c_one", 32'(q), 32'h02);
        check("w1c_irq_on", 32'(irq), 32'h1);
        wr(6, 8'h02);
        check("w1c_irq_off", 32'(irq), 32'h0);
        rd(6, q); check("w1c_zero", 32'(q), 32'h00);

        // unmapped address
        wr(7, 8'hFF);
        rd(7, q); check("unmapped", 32'(q), 32'h00);

        // random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            bus.stb_i = 1'($urandom_range(0, 1));
            bus.we_i  = 1'($urandom_range(0, 1));
            bus.adr_i = AW'($urandom_range(0, 7));
            bus.dat_i = N'($urandom);
            if ($urandom_range(0, 7) == 0) tb_pin = N'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        bus.stb_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
